sseg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.

---
 rtl/sseg_pkg.sv | 38 +++
 rtl/hex7_decoder.sv | 11 +
 rtl/sseg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants, display word type and hex-to-segment table for the
// 7-segment scan controller.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // One displayable frame: four hex digits plus their decimal points.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
    } disp_word_t;

    // Active-low segments, bit6=g ... bit0=a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment scan controller with
// per-slot blanking and frame-synchronous value commit.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  dig_en,
    input  logic        load,
    output logic        busy,
    output logic        frame_tick,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          slot_en_q, slot_en_cur;
    disp_word_t    shadow_q, shadow_d, pending_q, pending_d;
    logic          busy_q, busy_d;
    logic          frame_tick_q;
    logic          commit, drive;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    assign commit = (cnt_q == CNT_MAX) && (idx_q == 2'd3);

    // At slot start the enable is taken live so a zero-length blank still works.
    assign slot_en_cur = (cnt_q == '0) ? dig_en[idx_q] : slot_en_q;
    assign drive       = (cnt_q >= CNT_BLANK) && slot_en_cur;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        if (commit && load) begin
            shadow_d = '{value: value, dp: dp_in};
            busy_d   = 1'b0;
        end else if (commit && busy_q) begin
            shadow_d = pending_q;
            busy_d   = 1'b0;
        end else if (load) begin
            pending_d = '{value: value, dp: dp_in};
            busy_d    = 1'b1;
        end
    end

    assign nibble = shadow_q.value[{idx_q, 2'b00} +: 4];

    hex7_decoder u_dec (
        .hex (nibble),
        .seg (seg_dec)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (drive) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_dec;
            dp_d  = ~shadow_q.dp[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            slot_en_q    <= 1'b0;
            shadow_q     <= '0;
            pending_q    <= '0;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            slot_en_q    <= slot_en_cur;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            frame_tick_q <= commit;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign busy       = busy_q;
    assign frame_tick = frame_tick_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: directed scenarios plus random
// loads/enables, compared every cycle against a cycle-count-based model.
module tb_sseg_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  dig_en = 4'hF;
    logic        load = 1'b0;
    logic        busy, frame_tick, dp;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: time is just the edge count since reset release.
    int          m_n;
    logic [15:0] m_shadow, m_pend;
    logic [3:0]  m_sdp, m_pdp;
    logic        m_busy, m_slot_en;
    logic [3:0]  last_e_an;
    logic [6:0]  dec_tab [16];

    sseg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .dig_en     (dig_en),
        .load       (load),
        .busy       (busy),
        .frame_tick (frame_tick),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_n = 0;
        m_shadow = '0;
        m_pend = '0;
        m_sdp = '0;
        m_pdp = '0;
        m_busy = 1'b0;
        m_slot_en = 1'b0;
        last_e_an = 4'hF;
    endfunction

    function automatic bit next_is_commit();
        return (m_n % SD == SD - 1) && ((m_n / SD) % 4 == 3);
    endfunction

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                        input logic [3:0] en);
        int         cnt, idx;
        logic       en_now, drv, cm;
        logic [3:0] e_an, nib;
        logic [6:0] e_seg;
        logic       e_dp;
        @(negedge clk);
        load = ld;
        value = v;
        dp_in = d;
        dig_en = en;
        cnt = m_n % SD;
        idx = (m_n / SD) % 4;
        en_now = (cnt == 0) ? en[idx] : m_slot_en;
        m_slot_en = en_now;
        drv = (cnt >= BC) && en_now;
        nib = 4'(m_shadow >> (4 * idx));
        e_an = drv ? ~(4'b0001 << idx) : 4'hF;
        e_seg = drv ? dec_tab[nib] : 7'h7F;
        e_dp = drv ? ~m_sdp[idx] : 1'b1;
        cm = (cnt == SD - 1) && (idx == 3);
        if (cm && ld) begin
            m_shadow = v;
            m_sdp = d;
            m_busy = 1'b0;
        end else if (cm && m_busy) begin
            m_shadow = m_pend;
            m_sdp = m_pdp;
            m_busy = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_pdp = d;
            m_busy = 1'b1;
        end
        m_n++;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("busy", 32'(busy), 32'(m_busy));
        check("frame_tick", 32'(frame_tick), 32'(cm));
        last_e_an = e_an;
    endtask

    task automatic idle(input int n, input logic [3:0] en);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, en);
    endtask

    initial begin
        logic [3:0] cur_en;
        int         guard;
        dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();

        // Held in reset: display dark, nothing pending.
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ft", 32'(frame_tick), 32'h0);
        #1 rst_n = 1'b1;

        idle(10, 4'hF);
        step(1'b1, 16'h1234, 4'h0, 4'hF);
        idle(70, 4'hF);

        idle(70, 4'b0101);

        guard = 0;
        while (!next_is_commit() && guard < 64) begin
            step(1'b0, 16'h0, 4'h0, 4'hF);
            guard++;
        end
        step(1'b1, 16'h9C3E, 4'h3, 4'hF);
        idle(40, 4'hF);

        step(1'b1, 16'hAAAA, 4'h0, 4'hF);
        idle(3, 4'hF);
        step(1'b1, 16'h5555, 4'h0, 4'hF);
        idle(70, 4'hF);

        step(1'b1, 16'h0000, 4'b1000, 4'hF);
        idle(70, 4'hF);

        step(1'b1, 16'hFEDC, 4'h0, 4'hF);
        idle(70, 4'hF);
        step(1'b1, 16'hBA98, 4'h0, 4'hF);
        idle(70, 4'hF);

        // Asynchronous reset while a digit is being driven.
        guard = 0;
        while (last_e_an == 4'hF && guard < 100) begin
            step(1'b0, 16'h0, 4'h0, 4'hF);
            guard++;
        end
        check("async_find_drive", 32'(last_e_an != 4'hF), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'h1);
        check("async_busy", 32'(busy), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        idle(40, 4'hF);

        cur_en = 4'hF;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 39) == 0) cur_en = 4'($urandom);
            step($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom), cur_en);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
